// File: rtl/commit_trace_packer.sv
// commit_trace_packer
//   Buffers retired-instruction records from the core monitor in a small FIFO
//   and serialises each record as one variable-length frame of 32-bit words
//   on a valid/ready stream. Commits that find the buffer full are counted
//   as drops.
//
//   Ports:
//     clk        rising-edge clock for all state
//     rst_n      synchronous active-low reset
//     mon        retired-instruction record (mon.commit marks a retirement)
//     out_valid  trace word valid (a record is buffered)
//     out_ready  sink accepts the word when high together with out_valid
//     out_data   trace word
//     out_last   final word of the current frame
//     drop_cnt   saturating count of commits lost to overflow
//     level      number of records currently buffered

package rv32i_types;
    typedef struct packed {
        logic        commit;
        logic        trap;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] instruction;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } monitor_t;
endpackage

module commit_trace_packer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  rv32i_types::monitor_t    mon,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic                     out_last,
    output logic [15:0]              drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef struct packed {
        logic [7:0]  seq;
        logic        trap;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] instruction;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rec_t;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    rec_t          mem [DEPTH];
    rec_t          head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [2:0]    word_idx;
    logic [2:0]    last_idx;
    logic [7:0]    seq;
    logic [31:0]   word;
    logic          pop;
    logic          capture;
    state_t        state;
    state_t        state_next;

    assign head = mem[rd_ptr];

    // Word slots 5..7 are packed: a frame without memory access stops at 4,
    // and mem_wdata slides into slot 6 when there was no read.
    always_comb begin
        word = '0;
        unique case (word_idx)
            3'd0:    word = {8'hA5, head.seq, head.trap, head.rd_addr,
                             head.rs1_addr, head.rs2_addr};
            3'd1:    word = head.instruction;
            3'd2:    word = head.pc_rdata;
            3'd3:    word = head.pc_wdata;
            3'd4:    word = {head.mem_rmask, head.mem_wmask, 24'h0};
            3'd5:    word = head.mem_addr;
            3'd6:    word = (head.mem_rmask != 4'h0) ? head.mem_rdata : head.mem_wdata;
            default: word = head.mem_wdata;
        endcase

        last_idx = 3'd4;
        if ((head.mem_rmask | head.mem_wmask) != 4'h0) begin
            last_idx = ((head.mem_rmask != 4'h0) && (head.mem_wmask != 4'h0)) ? 3'd7 : 3'd6;
        end
    end

    assign out_valid = (state == SEND);
    assign out_data  = out_valid ? word : '0;
    assign out_last  = out_valid && (word_idx == last_idx);
    assign pop       = out_valid && out_ready && out_last;
    // A full buffer still accepts a commit when the head frame finishes this cycle.
    assign capture   = mon.commit && ((level != LW'(DEPTH)) || pop);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (capture) state_next = SEND;
            SEND: if (pop && (level == LW'(1)) && !capture) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            level    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_idx <= '0;
            seq      <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_next;

            if (capture && !pop) begin
                level <= level + LW'(1);
            end else if (!capture && pop) begin
                level <= level - LW'(1);
            end

            if (capture) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);

            if (out_valid && out_ready) begin
                word_idx <= out_last ? 3'd0 : word_idx + 3'd1;
            end

            if (mon.commit) begin
                seq <= seq + 8'd1;
                if (!capture && (drop_cnt != 16'hFFFF)) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && capture) begin
            mem[wr_ptr] <= '{
                seq:         seq,
                trap:        mon.trap,
                rd_addr:     mon.rd_addr,
                rs1_addr:    mon.rs1_addr,
                rs2_addr:    mon.rs2_addr,
                instruction: mon.instruction,
                pc_rdata:    mon.pc_rdata,
                pc_wdata:    mon.pc_wdata,
                mem_addr:    mon.mem_addr,
                mem_rmask:   mon.mem_rmask,
                mem_wmask:   mon.mem_wmask,
                mem_rdata:   mon.mem_rdata,
                mem_wdata:   mon.mem_wdata
            };
        end
    end

endmodule
